fifo_8x4_mux_out: RTL and testbench

Small synchronous FIFO that sits directly downstream of the 2x1 8-bit mux in the lane datapath. It captures each mux output byte qualified by the mux's output valid, buffers up to DEPTH entries, and delivers them in order to the next stage through a registered pop interface. Status flags (full/empty/almost-full/almost-empty) give the upstream stage backpressure and flow-control information. An overflow error flag is also provided.

---
 rtl/fifo_8x4_mux_out_if.sv | 31 +++
 rtl/fifo_8x4_mux_out.sv | 89 ++++++++
 tb/tb_fifo_8x4_mux_out.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fifo_8x4_mux_out_if.sv
// Bundle of the data, strobe and status signals between fifo_8x4_mux_out and its neighbours.
// The slave modport is the FIFO side. The master modport is the side that drives data and strobes.
interface fifo_8x4_mux_out_if #(
   parameter int DATA_WIDTH = 8
);
   // Handshake semantics:
   // - push is a write strobe; it is taken when the FIFO has room, or when it is full and pop is also high.
   // - pop is a read request; it is taken whenever the FIFO is non-empty.
   // - An accepted pop gives data_out with valid_out high on the following cycle.
   // - valid_out is a single-cycle pulse and has no ready.
   logic [DATA_WIDTH-1:0] data_in;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  error;

   modport slave (
      input  data_in, push, pop,
      output data_out, valid_out, full, empty, almost_full, almost_empty, error
   );

   modport master (
      output data_in, push, pop,
      input  data_out, valid_out, full, empty, almost_full, almost_empty, error
   );
endinterface

// File: rtl/fifo_8x4_mux_out.sv
// Small synchronous FIFO behind the lane mux, with a registered pop port and status/overflow flags.
// When FIFO_ERR_STICKY_EN is defined, error latches until reset. Otherwise it pulses once per overflow.
module fifo_8x4_mux_out #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int AF_THRESH  = 3,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset_L,
   fifo_8x4_mux_out_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  error_q;

   logic is_full;
   logic is_empty;
   logic push_ok;
   logic pop_ok;
   logic overflow;

   assign is_full  = (count == FULL_CNT);
   assign is_empty = (count == '0);
   // A pop frees a slot in the same edge, so a full FIFO can still accept a push alongside a pop.
   assign pop_ok   = bus.pop && !is_empty;
   assign push_ok  = bus.push && (!is_full || bus.pop);
   assign overflow = bus.push && is_full && !bus.pop;

   // Storage has no reset; its contents are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= pop_ok;
         if (pop_ok) begin
            data_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         error_q <= 1'b0;
      end else begin
`ifdef FIFO_ERR_STICKY_EN
         error_q <= error_q | overflow;
`else
         error_q <= overflow;
`endif
      end
   end

   assign bus.data_out     = data_q;
   assign bus.valid_out    = valid_q;
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.almost_full  = (count >= AF_CNT);
   assign bus.almost_empty = (count <= AE_CNT);
   assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_8x4_mux_out.sv
// Self-checking bench for fifo_8x4_mux_out.
// A reference FIFO model feeds an expected-output queue; every cycle checks data, valid, flags and error.
module tb_fifo_8x4_mux_out;
   localparam int W = 8;
   localparam int DEPTH = 4;

   logic clk;
   logic reset_L;
   int   errors;
   int   checks;

   fifo_8x4_mux_out_if #(.DATA_WIDTH(W)) bus ();

   fifo_8x4_mux_out dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   logic [W-1:0] exp_q[$];   // bytes expected on data_out, in order
   logic [W-1:0] mdl_q[$];   // reference FIFO contents
   logic [W-1:0] last_data;
   logic         m_err;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_flags(input string tag);
      int n;
      n = mdl_q.size();
      check_eq({tag, ".full"},  32'(bus.full),         32'(n == DEPTH));
      check_eq({tag, ".empty"}, 32'(bus.empty),        32'(n == 0));
      check_eq({tag, ".af"},    32'(bus.almost_full),  32'(n >= 3));
      check_eq({tag, ".ae"},    32'(bus.almost_empty), 32'(n <= 1));
      check_eq({tag, ".err"},   32'(bus.error),        32'(m_err));
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, ".data"},  32'(bus.data_out),     32'h00);
      check_eq({tag, ".valid"}, 32'(bus.valid_out),    32'd0);
      check_eq({tag, ".empty"}, 32'(bus.empty),        32'd1);
      check_eq({tag, ".ae"},    32'(bus.almost_empty), 32'd1);
      check_eq({tag, ".full"},  32'(bus.full),         32'd0);
      check_eq({tag, ".af"},    32'(bus.almost_full),  32'd0);
      check_eq({tag, ".err"},   32'(bus.error),        32'd0);
   endtask

   task automatic clear_model();
      exp_q.delete();
      mdl_q.delete();
      last_data = '0;
      m_err = 1'b0;
   endtask

   // ---------------- driver ----------------
   // Drive one cycle, advance the model, then check the outputs 1 time unit after the edge.
   task automatic cycle(input logic push, input logic pop, input logic [W-1:0] data, input string tag);
      logic pop_acc;
      logic push_acc;
      logic ovf;
      logic [W-1:0] exp;
      bus.push    = push;
      bus.pop     = pop;
      bus.data_in = data;
      pop_acc  = pop && (mdl_q.size() > 0);
      push_acc = push && ((mdl_q.size() < DEPTH) || pop);
      ovf      = push && (mdl_q.size() == DEPTH) && !pop;
      if (pop_acc) exp_q.push_back(mdl_q.pop_front());
      if (push_acc) mdl_q.push_back(data);
`ifdef FIFO_ERR_STICKY_EN
      m_err = m_err | ovf;
`else
      m_err = ovf;
`endif
      @(posedge clk);
      #1;
      check_eq({tag, ".valid"}, 32'(bus.valid_out), 32'(pop_acc));
      if (pop_acc) begin
         exp = exp_q.pop_front();
         last_data = exp;
      end
      check_eq({tag, ".data"}, 32'(bus.data_out), 32'(last_data));
      check_flags(tag);
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   // Assert reset between clock edges and check that the outputs clear without waiting for an edge.
   task automatic async_reset(input string tag);
      reset_L = 1'b0;
      bus.push    = 1'($urandom_range(0, 1));
      bus.pop     = 1'($urandom_range(0, 1));
      bus.data_in = W'($urandom_range(0, 255));
      #1;
      clear_model();
      check_reset_values({tag, ".async"});
      @(posedge clk);
      #1;
      check_reset_values({tag, ".held"});
      #2;
      reset_L = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      errors = 0;
      checks = 0;
      reset_L = 1'b0;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.data_in = '0;
      clear_model();
      #2;
      for (int i = 0; i < 3; i++) begin
         bus.push    = 1'($urandom_range(0, 1));
         bus.pop     = 1'($urandom_range(0, 1));
         bus.data_in = W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         check_reset_values("reset");
      end
      #2;
      reset_L = 1'b1;
      bus.push = 1'b0;
      bus.pop = 1'b0;

      // Fill and drain.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(8'hA1 + i), "fill");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "drain");
      cycle(1'b0, 1'b0, 8'h00, "idle");

      // Overflow: 0xFF is dropped.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(8'h10 + i), "ovf_fill");
      cycle(1'b1, 1'b0, 8'hFF, "ovf_push");
      cycle(1'b0, 1'b0, 8'h00, "ovf_after1");
      cycle(1'b0, 1'b0, 8'h00, "ovf_after2");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "ovf_drain");
      cycle(1'b0, 1'b1, 8'h00, "ovf_pop_empty");

      // Simultaneous push/pop while full.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(8'h20 + i), "fpp_fill");
      cycle(1'b1, 1'b1, 8'h24, "fpp_both");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, "fpp_drain");

      // Empty corner cases.
      cycle(1'b0, 1'b1, 8'h00, "empty_pop");
      cycle(1'b1, 1'b1, 8'h55, "empty_pushpop");
      cycle(1'b0, 1'b1, 8'h00, "empty_next_pop");

      // Reset in the middle of operation.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(8'h30 + i), "mid_fill");
      async_reset("mid_reset");
      cycle(1'b1, 1'b0, 8'h77, "post_push");
      cycle(1'b0, 1'b1, 8'h00, "post_pop");
      cycle(1'b0, 1'b1, 8'h00, "post_pop_empty");

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 0 : 1),
               W'($urandom_range(0, 255)), "rand");
         if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b0, W'($urandom_range(0, 255)), "rand_push");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
